subtractor_32bit_seq: RTL and testbench

// - Multi-cycle 32-bit borrow-chain subtractor, the inverse operation of the 32-bit full-adder datapath.
// - Computes D = A - B - Bin one SLICE_W-bit slice per clock, rippling the borrow between slices through a register.
// - Valid/ready handshake on input and output, so it sits on the same operand bus as the adder.
//

---
 rtl/subtractor_32bit_seq.sv | 140 ++++++++++++++
 tb/tb_subtractor_32bit_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_32bit_seq.sv
// ---------------------------------------------------------------------------
// subtractor_32bit_seq
//
// Multi-cycle borrow-chain subtractor computing D = A - B - Bin.
// It handles one SLICE_W-bit slice per clock. The borrow ripples from slice
// k to slice k+1 through a register. Valid/ready handshakes on the input and
// output sides let it share an operand bus with the matching adder datapath.
//
// Parameters
//   WIDTH     operand/result width; must be a multiple of SLICE_W
//   SLICE_W   bits subtracted per RUN cycle (N = WIDTH/SLICE_W RUN cycles)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (high only in IDLE)
//   A, B, Bin  minuend, subtrahend, borrow in
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   D          difference, (A - B - Bin) mod 2^WIDTH
//   Bout       borrow out, 1 iff A < B + Bin (unsigned)
//   Z, V       zero / signed-overflow flags (only when SUB_FLAGS_EN is defined)
//
// Optional feature macro: SUB_FLAGS_EN adds the Z and V flag outputs.
// ---------------------------------------------------------------------------
module subtractor_32bit_seq #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               borrow;
  logic [CNT_W-1:0]   count;

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W:0]   slice_diff;
  logic [WIDTH-1:0]   d_next;
  logic               last_slice;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Current slice arithmetic. The subtraction is done one bit wider than the
  // slice, so the extra MSB is set exactly when the slice result went
  // negative; that MSB is the borrow into the next slice.
  // d_next is D with the current slice merged in, so the flags can be taken
  // from the complete result on the same edge as the final slice.
  always_comb begin
    a_slice    = a_reg[count*SLICE_W +: SLICE_W];
    b_slice    = b_reg[count*SLICE_W +: SLICE_W];
    slice_diff = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE_W{1'b0}}, borrow};
    d_next     = D;
    d_next[count*SLICE_W +: SLICE_W] = slice_diff[SLICE_W-1:0];
    last_slice = (count == CNT_W'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      count  <= '0;
      D      <= '0;
      Bout   <= 1'b0;
`ifdef SUB_FLAGS_EN
      Z      <= 1'b0;
      V      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= Bin;
            count  <= '0;
            D      <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          D      <= d_next;
          borrow <= slice_diff[SLICE_W];
          count  <= count + 1'b1;
          if (last_slice) begin
            Bout  <= slice_diff[SLICE_W];
`ifdef SUB_FLAGS_EN
            Z     <= (d_next == '0);
            V     <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                     (d_next[WIDTH-1] != a_reg[WIDTH-1]);
`endif
            state <= DONE;
          end
        end

        DONE: begin
          // Results stay frozen until the consumer takes them.
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// ---------------------------------------------------------------------------
// tb_subtractor_32bit_seq
//
// Directed testbench for subtractor_32bit_seq at default parameters (N=4).
// Each operation is handed over with a valid/ready handshake. The bench
// checks the result, the borrow, the accept-to-valid latency, backpressure
// holding, and an abort by reset in the middle of RUN.
// Flag checks are compiled in when SUB_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_subtractor_32bit_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
`ifdef SUB_FLAGS_EN
  logic        Z;
  logic        V;
`endif

  int checks;
  int failures;
  int latency;

  subtractor_32bit_seq #(
    .WIDTH  (32),
    .SLICE_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .Bout     (Bout)
`ifdef SUB_FLAGS_EN
    ,
    .Z        (Z),
    .V        (V)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one operation, waits for it to be accepted, then waits for
  // out_valid and records how many cycles that took. The block is left
  // in DONE.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic bin);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    A        = a;
    B        = b;
    Bin      = bin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
    latency = 0;
    while (!out_valid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
    checkOutput("out_valid_reached", 32'(out_valid), 32'd1);
  endtask

  // Hands the result to the consumer and checks the return to IDLE.
  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_dropped", 32'(out_valid), 32'd0);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_D", D, 32'h0);
    checkOutput("reset_Bout", 32'(Bout), 32'd0);
`ifdef SUB_FLAGS_EN
    checkOutput("reset_Z", 32'(Z), 32'd0);
    checkOutput("reset_V", 32'(V), 32'd0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 - 3 = 2, with the latency check.
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
    checkOutput("small_latency", latency, 32'd4);
    checkOutput("small_D", D, 32'h0000_0002);
    checkOutput("small_Bout", 32'(Bout), 32'd0);
    releaseResult();

    // 0 - 1: the borrow ripples through every slice.
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0);
    checkOutput("wrap_D", D, 32'hFFFF_FFFF);
    checkOutput("wrap_Bout", 32'(Bout), 32'd1);
    releaseResult();

    // The borrow crosses two slices and then stops.
    applyStimulus(32'h0001_0000, 32'h0000_0001, 1'b0);
    checkOutput("mid_D", D, 32'h0000_FFFF);
    checkOutput("mid_Bout", 32'(Bout), 32'd0);
    releaseResult();

    // Most negative value minus 1 gives signed overflow.
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0);
    checkOutput("ovf_D", D, 32'h7FFF_FFFF);
    checkOutput("ovf_Bout", 32'(Bout), 32'd0);
`ifdef SUB_FLAGS_EN
    checkOutput("ovf_V", 32'(V), 32'd1);
    checkOutput("ovf_Z", 32'(Z), 32'd0);
`endif
    releaseResult();

    // Equal operands give zero.
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0);
    checkOutput("eq_D", D, 32'h0000_0000);
    checkOutput("eq_Bout", 32'(Bout), 32'd0);
`ifdef SUB_FLAGS_EN
    checkOutput("eq_Z", 32'(Z), 32'd1);
    checkOutput("eq_V", 32'(V), 32'd0);
`endif
    releaseResult();

    // Equal operands with borrow in.
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1);
    checkOutput("eqbin_D", D, 32'hFFFF_FFFF);
    checkOutput("eqbin_Bout", 32'(Bout), 32'd1);
`ifdef SUB_FLAGS_EN
    checkOutput("eqbin_Z", 32'(Z), 32'd0);
    checkOutput("eqbin_V", 32'(V), 32'd0);
`endif
    releaseResult();

    // Backpressure: hold DONE for 5 cycles while a second operation is
    // offered. It must not be taken.
    applyStimulus(32'h0000_0064, 32'h0000_0020, 1'b0);
    A        = 32'h0000_0100;
    B        = 32'h0000_0001;
    Bin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) in_valid = 1'b0;
      checkOutput("bp_D", D, 32'h0000_0044);
      checkOutput("bp_Bout", 32'(Bout), 32'd0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    releaseResult();
    applyStimulus(32'h0000_0100, 32'h0000_0001, 1'b0);
    checkOutput("second_D", D, 32'h0000_00FF);
    checkOutput("second_Bout", 32'(Bout), 32'd0);
    releaseResult();

    // Reset after two slices aborts the operation.
    A        = 32'hFFFF_FFFF;
    B        = 32'h0000_0001;
    Bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_D", D, 32'h0);
    checkOutput("abort_Bout", 32'(Bout), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_idle_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(32'h0000_0010, 32'h0000_0001, 1'b0);
    checkOutput("after_abort_latency", latency, 32'd4);
    checkOutput("after_abort_D", D, 32'h0000_000F);
    checkOutput("after_abort_Bout", 32'(Bout), 32'd0);
    releaseResult();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
